// File: rtl/flip_pattern_enumerator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flip_pattern_enumerator: streams every K-bit flip mask of weight 0..MAX_ORDER
// Revision: 1.0
// ---------------------------------------------------------------------------
module flip_pattern_enumerator #(
  parameter int K            = 8,
  parameter int MAX_ORDER    = 2,
  parameter int INCLUDE_ZERO = 1,
  localparam int N  = INCLUDE_ZERO + K
                    + ((MAX_ORDER >= 2) ? (K * (K - 1)) / 2 : 0)
                    + ((MAX_ORDER >= 3) ? (K * (K - 1) * (K - 2)) / 6 : 0),
  localparam int IW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          m_ready,
  output logic [K-1:0]  flip_mask,
  output logic [1:0]    weight,
  output logic [IW-1:0] index,
  output logic          valid,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(K) + 1;
  localparam logic [CW-1:0] K1 = CW'(K - 1);
  localparam logic [CW-1:0] K2 = CW'(K - 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [K-1:0]  ONE = K'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_d;
  logic [1:0]      w, w_d, nw;
  logic [CW-1:0]   i, j, l, i_d, j_d, l_d, ni, nj, nl;
  logic [IW-1:0]   idx, idx_d;
  logic [K-1:0]    mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w     <= '0;
      i     <= '0;
      j     <= '0;
      l     <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      w     <= w_d;
      i     <= i_d;
      j     <= j_d;
      l     <= l_d;
      idx   <= idx_d;
    end
  end

  // Successor tuple; the innermost position advances first, and exhausting a
  // weight rolls straight into the first tuple of the next weight.
  always_comb begin
    nw = w;
    ni = i;
    nj = j;
    nl = l;
    case (w)
      2'd0: begin
        nw = 2'd1;
        ni = '0;
      end
      2'd1: begin
        if (i == K1) begin
          nw = 2'd2;
          ni = '0;
          nj = CW'(1);
        end else begin
          ni = i + CW'(1);
        end
      end
      2'd2: begin
        if (j != K1) begin
          nj = j + CW'(1);
        end else if (i == K2) begin
          nw = 2'd3;
          ni = '0;
          nj = CW'(1);
          nl = CW'(2);
        end else begin
          ni = i + CW'(1);
          nj = i + CW'(2);
        end
      end
      default: begin
        if (l != K1) begin
          nl = l + CW'(1);
        end else if (j != K2) begin
          nj = j + CW'(1);
          nl = j + CW'(2);
        end else begin
          ni = i + CW'(1);
          nj = i + CW'(2);
          nl = i + CW'(3);
        end
      end
    endcase
  end

  always_comb begin
    state_d = state;
    w_d     = w;
    i_d     = i;
    j_d     = j;
    l_d     = l;
    idx_d   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          w_d     = (INCLUDE_ZERO != 0) ? 2'd0 : 2'd1;
          i_d     = '0;
          j_d     = '0;
          l_d     = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        // Abort and completion both park the tuple at all-zero for IDLE.
        if (abort || (m_ready && idx == LAST_IDX)) begin
          state_d = abort ? IDLE : DONE;
          w_d     = '0;
          i_d     = '0;
          j_d     = '0;
          l_d     = '0;
          idx_d   = '0;
        end else if (m_ready) begin
          w_d   = nw;
          i_d   = ni;
          j_d   = nj;
          l_d   = nl;
          idx_d = idx + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask = '0;
    if (w >= 2'd1) mask = mask | (ONE << i);
    if (w >= 2'd2) mask = mask | (ONE << j);
    if (w == 2'd3) mask = mask | (ONE << l);
  end

  assign flip_mask = mask;
  assign weight    = w;
  assign index     = idx;
  assign valid     = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign last      = (state == RUN) && (idx == LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_flip_pattern_enumerator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_flip_pattern_enumerator: directed-vector bench for flip_pattern_enumerator
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_flip_pattern_enumerator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic m_ready = 1'b0;
  logic start2 = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] mask1, idx1, mask2, idx2;
  logic [1:0] w1, w2;
  logic       valid1, last1, busy1, done1;
  logic       valid2, last2, busy2, done2;

  flip_pattern_enumerator #(.K(4), .MAX_ORDER(2), .INCLUDE_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .m_ready(m_ready),
    .flip_mask(mask1), .weight(w1), .index(idx1),
    .valid(valid1), .last(last1), .busy(busy1), .done(done1)
  );

  flip_pattern_enumerator #(.K(4), .MAX_ORDER(3), .INCLUDE_ZERO(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .m_ready(1'b1),
    .flip_mask(mask2), .weight(w2), .index(idx2),
    .valid(valid2), .last(last2), .busy(busy2), .done(done2)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] seq1 [0:10];
  logic [3:0] seq2 [0:13];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pattern(input int k);
    check($sformatf("valid[%0d]", k), 32'(valid1), 32'd1);
    check($sformatf("mask[%0d]", k),  32'(mask1),  32'(seq1[k]));
    check($sformatf("weight[%0d]", k), 32'(w1), (k == 0) ? 32'd0 : (k < 5) ? 32'd1 : 32'd2);
    check($sformatf("index[%0d]", k), 32'(idx1),   32'(k));
    check($sformatf("last[%0d]", k),  32'(last1),  (k == 10) ? 32'd1 : 32'd0);
    check($sformatf("busy[%0d]", k),  32'(busy1),  32'd1);
  endtask

  task automatic run_seq(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      @(negedge clk);
      check_pattern(k);
    end
  endtask

  task automatic check_done();
    @(negedge clk);
    check("done_pulse", 32'(done1), 32'd1);
    check("done_valid", 32'(valid1), 32'd0);
    check("done_busy",  32'(busy1), 32'd0);
    @(negedge clk);
    check("done_clear", 32'(done1), 32'd0);
    check("idle_valid", 32'(valid1), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mask"},  32'(mask1),  32'd0);
    check({tag, "_weight"}, 32'(w1),    32'd0);
    check({tag, "_index"}, 32'(idx1),   32'd0);
    check({tag, "_valid"}, 32'(valid1), 32'd0);
    check({tag, "_last"},  32'(last1),  32'd0);
    check({tag, "_busy"},  32'(busy1),  32'd0);
    check({tag, "_done"},  32'(done1),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    seq1 = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
             4'b0101, 4'b1001, 4'b0110, 4'b1010, 4'b1100};
    seq2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0101, 4'b1001,
             4'b0110, 4'b1010, 4'b1100, 4'b0111, 4'b1011, 4'b1101, 4'b1110};

    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_self_start", 32'(valid1), 32'd0);

    // Full run with start held high: ignored in RUN/DONE, honoured back-to-back.
    start = 1'b1;
    m_ready = 1'b1;
    run_seq(0, 10);
    check_done();
    run_seq(0, 0);
    start = 1'b0;
    run_seq(1, 10);
    check_done();
    @(negedge clk);
    check("stay_idle", 32'(valid1), 32'd0);

    // Backpressure at index 5.
    start = 1'b1;
    run_seq(0, 0);
    start = 1'b0;
    run_seq(1, 5);
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_valid",  32'(valid1), 32'd1);
      check("hold_mask",   32'(mask1),  32'h3);
      check("hold_weight", 32'(w1),     32'd2);
      check("hold_index",  32'(idx1),   32'd5);
      check("hold_last",   32'(last1),  32'd0);
    end
    m_ready = 1'b1;
    run_seq(6, 10);
    check_done();

    // Abort at index 7 with m_ready high.
    start = 1'b1;
    run_seq(0, 0);
    start = 1'b0;
    run_seq(1, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_all_zero("abort");
    @(negedge clk);
    check("abort_no_done", 32'(done1), 32'd0);

    // Restart with abort also high in IDLE, where it must be ignored.
    start = 1'b1;
    abort = 1'b1;
    run_seq(0, 0);
    start = 1'b0;
    abort = 1'b0;
    run_seq(1, 10);
    check_done();

    // Asynchronous reset at index 4, between clock edges.
    start = 1'b1;
    run_seq(0, 0);
    start = 1'b0;
    run_seq(1, 4);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(valid1), 32'd0);
    start = 1'b1;
    run_seq(0, 0);
    start = 1'b0;
    run_seq(1, 10);
    check_done();

    // Weight-3 configuration without the zero pattern.
    start2 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) start2 = 1'b0;
      check($sformatf("o3_valid[%0d]", k),  32'(valid2), 32'd1);
      check($sformatf("o3_mask[%0d]", k),   32'(mask2),  32'(seq2[k]));
      check($sformatf("o3_weight[%0d]", k), 32'(w2), (k < 4) ? 32'd1 : (k < 10) ? 32'd2 : 32'd3);
      check($sformatf("o3_index[%0d]", k),  32'(idx2),   32'(k));
      check($sformatf("o3_last[%0d]", k),   32'(last2),  (k == 13) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("o3_done_pulse", 32'(done2), 32'd1);
    check("o3_done_valid", 32'(valid2), 32'd0);
    @(negedge clk);
    check("o3_done_clear", 32'(done2), 32'd0);
    check("o3_idle_busy",  32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
